md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. Consumes the forwarded operands `SrcA_E`/`SrcB_E` produced by the EX operand-select logic. Executes MULT/MULTU/DIV/DIVU as multi-cycle operations into HI/LO and MTHI/MTLO as single-cycle writes. Exposes `Busy` to the hazard unit so that MD-class instructions in D stall while an operation is pending.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  one-cycle issue strobe for the MD instruction currently in E.
- `MDOp`  in  3  operation, sampled with `Start`: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110/111 are no-ops.
- `SrcA_E`  in  32  rs operand (forwarded).
- `SrcB_E`  in  32  rt operand (forwarded).
- `Busy`  out  1  high while a multi-cycle operation is in flight.
- `HI`  out  32  HI register (direct register output).
- `LO`  out  32  LO register (direct register output).

## Operation
- State: IDLE, RUN. Down-counter `cnt` (4 bits is sufficient for the defaults; width is derived from the larger parameter). Pending result registers `hi_p`, `lo_p`.
- In IDLE with `Start`=1:
  - MULT: {hi_p,lo_p} = signed 64-bit product of A×B.
  - MULTU: {hi_p,lo_p} = unsigned 64-bit product of A×B.
  - Both MULT and MULTU load `cnt`=MULT_CYCLES and go to RUN.
  - DIV: lo_p = signed quotient truncated toward zero; hi_p = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Both DIV and DIVU load `cnt`=DIV_CYCLES and go to RUN.
  - MTHI: HI←A at this edge. MTLO: LO←A at this edge. Neither changes state.
  - MDOp 110/111: no effect.
- Divide by zero (B=0, DIV or DIVU): RUN for DIV_CYCLES as normal, but HI/LO are left unchanged at completion. A flag latched at start suppresses the write.
- DIV with A=0x80000000 and B=0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- RUN: `cnt` decrements each cycle. On the edge where `cnt`==1, HI←hi_p, LO←lo_p (unless suppressed), `cnt`←0, and state goes to IDLE.
- `Busy` = (state==RUN).
- `Start` while in RUN is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never happens in normal flow; the bench checks that it is ignored.
- HI/LO are not visible as updated until completion. Reads (MFHI/MFLO) are stalled by the hazard unit on `Busy|Start`, so no bypass of pending results is provided.

## Timing
- Reset (synchronous, `reset`=1 at an edge): state=IDLE, `cnt`=0, `Busy`=0, HI=0, LO=0, hi_p=lo_p=0, suppress flag=0. Reset wins over `Start` in the same cycle.
- Reset mid-operation aborts the operation: no HI/LO write, `Busy`=0 after that edge.
- Edge t samples `Start` (multiply): `Busy`=1 during cycles t+1 … t+MULT_CYCLES. HI/LO hold the new values from the edge at end of cycle t+MULT_CYCLES. `Busy`=0 from then on.
- Divide: same pattern with DIV_CYCLES.
- Back-to-back: `Start` may be accepted in the first cycle after `Busy` falls.
- MTHI/MTLO: HI/LO updated at the sampling edge, visible the next cycle. `Busy` never asserts.

## Test plan
- Reset: hold `reset` 2 cycles with `Start`=1, MDOp=MTHI, A=5 → after reset HI=0, LO=0, `Busy`=0.
- MULT with A=0xFFFFFFFE (−2), B=3 → `Busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV with A=0xFFFFFFF9 (−7), B=2 → `Busy` high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with A=7, B=2 → LO=3, HI=1.
- Divide by zero: preset HI=0x11, LO=0x22 via MTHI/MTLO, then DIV with B=0 → `Busy` high 10 cycles; HI=0x11, LO=0x22 unchanged.
- `Start`=1 with MDOp=MTLO, A=0x55 during RUN of a MULT → ignored; LO holds the MULT result at completion, and the MULT result is not overwritten by 0x55.
- Reset asserted in the 3rd cycle of a DIV → `Busy`=0 and HI=LO=0 the next cycle; no later write occurs. A new MULT issued immediately afterwards completes correctly.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: multi-cycle MULT/MULTU/DIV/DIVU into HI/LO,
// single-cycle MTHI/MTLO, and a Busy flag for the hazard unit.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] SrcA_E,
   input  logic [31:0] SrcB_E,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic [31:0]     hi_p_r;
   logic [31:0]     lo_p_r;
   logic            suppress_r;
   logic            busy_r;
   logic [31:0]     hi_r;
   logic [31:0]     lo_r;

   logic [63:0]     prod_s_s;
   logic [63:0]     prod_u_s;
   logic [31:0]     a_mag_s;
   logic [31:0]     b_mag_s;
   logic [31:0]     div_b_s;
   logic [31:0]     q_mag_s;
   logic [31:0]     r_mag_s;
   logic [31:0]     quot_s_s;
   logic [31:0]     rem_s_s;
   logic [31:0]     quot_u_s;
   logic [31:0]     rem_u_s;

   // Low 64 bits of the product of sign-extended operands equal the signed product
   assign prod_s_s = {{32{SrcA_E[31]}}, SrcA_E} * {{32{SrcB_E[31]}}, SrcB_E};
   assign prod_u_s = {32'd0, SrcA_E} * {32'd0, SrcB_E};

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 with no trap
   always_comb begin
      a_mag_s  = 32'd0;
      b_mag_s  = 32'd0;
      div_b_s  = 32'd1;
      quot_s_s = 32'd0;
      rem_s_s  = 32'd0;
      if (SrcA_E[31]) a_mag_s = 32'd0 - SrcA_E;
      else            a_mag_s = SrcA_E;
      if (SrcB_E[31]) b_mag_s = 32'd0 - SrcB_E;
      else            b_mag_s = SrcB_E;
      if (SrcB_E == 32'd0) div_b_s = 32'd1;
      else                 div_b_s = SrcB_E;
      if (SrcA_E[31] ^ SrcB_E[31]) quot_s_s = 32'd0 - q_mag_s;
      else                         quot_s_s = q_mag_s;
      if (SrcA_E[31]) rem_s_s = 32'd0 - r_mag_s;
      else            rem_s_s = r_mag_s;
   end

   // A zero divisor only selects the safe divisor; the write is suppressed later
   assign q_mag_s  = a_mag_s / ((b_mag_s == 32'd0) ? 32'd1 : b_mag_s);
   assign r_mag_s  = a_mag_s % ((b_mag_s == 32'd0) ? 32'd1 : b_mag_s);
   assign quot_u_s = SrcA_E / div_b_s;
   assign rem_u_s  = SrcA_E % div_b_s;

   // Control FSM, pending results, and the architectural HI/LO registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         hi_p_r     <= 32'd0;
         lo_p_r     <= 32'd0;
         suppress_r <= 1'b0;
         busy_r     <= 1'b0;
         hi_r       <= 32'd0;
         lo_r       <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (Start) begin
                  case (MDOp)
                     3'b000, 3'b001: begin
                        {hi_p_r, lo_p_r} <= (MDOp == 3'b000) ? prod_s_s : prod_u_s;
                        suppress_r       <= 1'b0;
                        cnt_r            <= CW'(MULT_CYCLES);
                        state_r          <= RUN;
                        busy_r           <= 1'b1;
                     end
                     3'b010, 3'b011: begin
                        lo_p_r     <= (MDOp == 3'b010) ? quot_s_s : quot_u_s;
                        hi_p_r     <= (MDOp == 3'b010) ? rem_s_s  : rem_u_s;
                        suppress_r <= (SrcB_E == 32'd0);
                        cnt_r      <= CW'(DIV_CYCLES);
                        state_r    <= RUN;
                        busy_r     <= 1'b1;
                     end
                     3'b100:  hi_r <= SrcA_E;
                     3'b101:  lo_r <= SrcA_E;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt_r == CW'(1)) begin
                  if (!suppress_r) begin
                     hi_r <= hi_p_r;
                     lo_r <= lo_p_r;
                  end
                  cnt_r   <= '0;
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign Busy = busy_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO queued at issue, compared at completion.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] SrcA_E;
   logic [31:0] SrcB_E;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [63:0] sb_q[$];

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
      .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else pass_cnt++;
   endtask

   // Issue a multi-cycle op, optionally poke MTLO while busy, then check length and result
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int cycles, input bit poke);
      int n;
      logic [63:0] e;
      @(negedge clk);
      Start = 1'b1; MDOp = op; SrcA_E = a; SrcB_E = b;
      sb_q.push_back({exp_hi, exp_lo});
      @(negedge clk);
      Start = 1'b0;
      n = 0;
      while (Busy && n < 50) begin
         n++;
         if (poke && n == 1) begin
            Start = 1'b1; MDOp = 3'b101; SrcA_E = 32'h55;
         end else begin
            Start = 1'b0;
         end
         @(negedge clk);
      end
      Start = 1'b0;
      check({tag, "_busy_len"}, 64'(n), 64'(cycles));
      e = sb_q.pop_front();
      check({tag, "_hilo"}, {HI, LO}, e);
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      Start = 1'b1; MDOp = op; SrcA_E = a; SrcB_E = 32'd0;
      @(negedge clk);
      Start = 1'b0;
      check("mt_busy", {63'd0, Busy}, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      longint sa, sb;
      logic [63:0] p;
      reset = 1'b1; Start = 1'b1; MDOp = 3'b100; SrcA_E = 32'd5; SrcB_E = 32'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; Start = 1'b0;
      check("reset_hi", {32'd0, HI}, 64'd0);
      check("reset_lo", {32'd0, LO}, 64'd0);
      check("reset_busy", {63'd0, Busy}, 64'd0);

      run_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b0);
      run_op("multu", 3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, 1'b0);
      run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
      run_op("div_nb",3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 1'b0);
      run_op("divu",  3'b011, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
      run_op("div_ovf",3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0);

      mt(3'b100, 32'h11);
      check("mthi_hi", {32'd0, HI}, 64'h11);
      mt(3'b101, 32'h22);
      check("mtlo_lo", {32'd0, LO}, 64'h22);
      run_op("div0",  3'b010, 32'd9, 32'd0, 32'h11, 32'h22, 10, 1'b0);
      run_op("divu0", 3'b011, 32'd9, 32'd0, 32'h11, 32'h22, 10, 1'b0);

      mt(3'b110, 32'h99);
      check("nop_hilo", {HI, LO}, {32'h11, 32'h22});

      run_op("mult_poke", 3'b000, 32'd1000, 32'd7, 32'd0, 32'd7000, 5, 1'b1);

      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom;
         sa = longint'($signed(a)); sb = longint'($signed(b));
         p = 64'(sa * sb);
         run_op("rnd_mult", 3'b000, a, b, p[63:32], p[31:0], 5, 1'b0);
         p = {32'd0, a} * {32'd0, b};
         run_op("rnd_multu", 3'b001, a, b, p[63:32], p[31:0], 5, 1'b0);
         b = $urandom_range(1, 5000);
         run_op("rnd_divu", 3'b011, a, b, a % b, a / b, 10, 1'b0);
      end

      // Abort a divide with reset in its third busy cycle
      @(negedge clk);
      Start = 1'b1; MDOp = 3'b011; SrcA_E = 32'd100; SrcB_E = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {63'd0, Busy}, 64'd0);
      check("abort_hilo", {HI, LO}, 64'd0);
      repeat (12) @(negedge clk);
      check("abort_nowrite", {HI, LO}, 64'd0);
      run_op("mult_after", 3'b001, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 5, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
